// File: rtl/seven_seg_shifter.sv
// Serialises DIGITS segment bytes (digit DIGITS-1 first, MSB first) into a
// 74HC595-style chain. Each frame ends with a storage latch pulse.
module seven_seg_shifter #(
    parameter int DIGITS  = 6,
    parameter int CLK_DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DIGITS*7-1:0]   seven_seg_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  update_i,
    output logic                  busy_o,
    output logic                  ser_data_o,
    output logic                  ser_clk_o,
    output logic                  ser_latch_o
);

    localparam int N  = DIGITS * 8;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = $clog2(N);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        LATCH
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_reg, div_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [N-1:0]    shift_reg, shift_next;
    logic            pending_reg, pending_next;
    logic            busy_reg, data_reg, sclk_reg, latch_reg;
    logic [N-1:0]    frame_capture;
    logic            div_done;

    // Digit DIGITS-1 sits in the top byte so it leaves the shift register first.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_frame
            assign frame_capture[gi*8 +: 8] = {dp_i[gi], seven_seg_i[gi*7 +: 7]};
        end
    endgenerate

    assign div_done = (div_reg == DIV_LAST);

    always_comb begin
        state_next   = state_reg;
        div_next     = div_reg;
        idx_next     = idx_reg;
        shift_next   = shift_reg;
        pending_next = pending_reg | (update_i && (state_reg != IDLE));
        case (state_reg)
            IDLE: begin
                if (update_i) begin
                    shift_next = frame_capture;
                    idx_next   = '0;
                    div_next   = '0;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (div_done) begin
                    div_next   = '0;
                    state_next = HIGH;
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            HIGH: begin
                if (div_done) begin
                    div_next = '0;
                    if (idx_reg != IDX_LAST) begin
                        shift_next = {shift_reg[N-2:0], 1'b0};
                        idx_next   = idx_reg + 1'b1;
                        state_next = LOW;
                    end else begin
                        state_next = LATCH;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            LATCH: begin
                if (div_done) begin
                    div_next = '0;
                    // A request on this very edge is folded in with any pending one.
                    if (pending_reg || update_i) begin
                        pending_next = 1'b0;
                        shift_next   = frame_capture;
                        idx_next     = '0;
                        state_next   = LOW;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they align with state_reg.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            div_reg     <= '0;
            idx_reg     <= '0;
            shift_reg   <= '0;
            pending_reg <= 1'b0;
            busy_reg    <= 1'b0;
            data_reg    <= 1'b0;
            sclk_reg    <= 1'b0;
            latch_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            div_reg     <= div_next;
            idx_reg     <= idx_next;
            shift_reg   <= shift_next;
            pending_reg <= pending_next;
            busy_reg    <= (state_next != IDLE);
            data_reg    <= ((state_next == LOW) || (state_next == HIGH)) ? shift_next[N-1] : 1'b0;
            sclk_reg    <= (state_next == HIGH);
            latch_reg   <= (state_next == LATCH);
        end
    end

    assign busy_o      = busy_reg;
    assign ser_data_o  = data_reg;
    assign ser_clk_o   = sclk_reg;
    assign ser_latch_o = latch_reg;

endmodule

// File: tb/tb_seven_seg_shifter.sv
// Bench for seven_seg_shifter: two instances (2 digits / div 2, 6 digits / div 1)
// observed by a serial-side monitor and compared with a bit-level frame model.
module tb_seven_seg_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [13:0] seg_a;
    logic [1:0]  dp_a;
    logic        upd_a;
    logic        busy_a, data_a, sclk_a, lat_a;
    logic [41:0] seg_b;
    logic [5:0]  dp_b;
    logic        upd_b;
    logic        busy_b, data_b, sclk_b, lat_b;

    int checks = 0;
    int errors = 0;

    seven_seg_shifter #(.DIGITS(2), .CLK_DIV(2)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .seven_seg_i(seg_a), .dp_i(dp_a), .update_i(upd_a),
        .busy_o(busy_a), .ser_data_o(data_a), .ser_clk_o(sclk_a), .ser_latch_o(lat_a)
    );

    seven_seg_shifter #(.DIGITS(6), .CLK_DIV(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .seven_seg_i(seg_b), .dp_i(dp_b), .update_i(upd_b),
        .busy_o(busy_b), .ser_data_o(data_b), .ser_clk_o(sclk_b), .ser_latch_o(lat_b)
    );

    // Serial-side monitor state, one slot per instance
    int          nbits[2]      = '{0, 0};
    int          last_nbits[2] = '{0, 0};
    int          frame_cnt[2]  = '{0, 0};
    int          latw[2]       = '{0, 0};
    int          last_latw[2]  = '{0, 0};
    int          brun[2]       = '{0, 0};
    int          last_busy[2]  = '{0, 0};
    logic [63:0] cur_bits[2]   = '{64'd0, 64'd0};
    logic [63:0] last_frame[2] = '{64'd0, 64'd0};
    logic [63:0] prev_frame[2] = '{64'd0, 64'd0};
    logic        prev_c[2]     = '{1'b0, 1'b0};
    logic        prev_l[2]     = '{1'b0, 1'b0};
    logic        prev_b[2]     = '{1'b0, 1'b0};

    task automatic mon_step(input int i, input logic b, input logic d, input logic c, input logic l);
        if (!b) begin
            nbits[i]    = 0;
            cur_bits[i] = 64'd0;
        end
        if (c && !prev_c[i]) begin
            cur_bits[i] = {cur_bits[i][62:0], d};
            nbits[i]++;
        end
        if (l && !prev_l[i]) begin
            prev_frame[i] = last_frame[i];
            last_frame[i] = cur_bits[i];
            last_nbits[i] = nbits[i];
            frame_cnt[i]++;
            nbits[i]    = 0;
            cur_bits[i] = 64'd0;
            latw[i]     = 0;
        end
        if (l) latw[i]++;
        if (!l && prev_l[i]) last_latw[i] = latw[i];
        if (b) begin
            brun[i]++;
        end else begin
            if (prev_b[i]) last_busy[i] = brun[i];
            brun[i] = 0;
        end
        prev_c[i] = c;
        prev_l[i] = l;
        prev_b[i] = b;
    endtask

    always @(negedge clk) begin
        mon_step(0, busy_a, data_a, sclk_a, lat_a);
        mon_step(1, busy_b, data_b, sclk_b, lat_b);
    end

    // Frame as the chain should see it: bit k of the frame is the k-th bit shifted in.
    function automatic logic [63:0] model(input int digits, input logic [47:0] seg, input logic [7:0] dp);
        logic [63:0] e = 64'd0;
        for (int k = 0; k < digits * 8; k++) begin
            int d = digits - 1 - k / 8;
            int p = k % 8;
            logic bv = (p == 0) ? dp[d] : seg[d*7 + 7 - p];
            e = {e[62:0], bv};
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic busy_of(input int i);
        return (i == 0) ? busy_a : busy_b;
    endfunction

    task automatic wait_idle(input int i, input int budget);
        int n = 0;
        while (busy_of(i) && n < budget) begin
            tick;
            n++;
        end
        check("done_in_budget", {63'd0, busy_of(i)}, 64'd0);
        tick;
    endtask

    task automatic verify(input int i, input string tag, input logic [63:0] exp, input int nb,
                          input int blen, input int lw, input int fc0, input int nfr);
        $display("frame inst=%0d tag=%s bits=%0d data=%h busy=%0d", i, tag, last_nbits[i], last_frame[i], last_busy[i]);
        check({tag, "_frames"}, 64'(frame_cnt[i] - fc0), 64'(nfr));
        check({tag, "_nbits"}, 64'(last_nbits[i]), 64'(nb));
        check({tag, "_data"}, last_frame[i], exp);
        check({tag, "_busy_len"}, 64'(last_busy[i]), 64'(blen));
        check({tag, "_latch_w"}, 64'(last_latw[i]), 64'(lw));
    endtask

    task automatic wait_bits_a(input int target);
        int n = 0;
        while (nbits[0] < target && n < 300) begin
            tick;
            n++;
        end
        check("reach_bit", 64'(nbits[0]), 64'(target));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e1;
        logic [63:0] e2;
        int fc;

        rst = 1'b1; upd_a = 1'b1; upd_b = 1'b1;
        seg_a = '0; dp_a = '0; seg_b = '0; dp_b = '0;
        tick;
        check("rst1_a", {60'd0, busy_a, data_a, sclk_a, lat_a}, 64'd0);
        check("rst1_b", {60'd0, busy_b, data_b, sclk_b, lat_b}, 64'd0);
        tick;
        check("rst2_a", {60'd0, busy_a, data_a, sclk_a, lat_a}, 64'd0);
        rst = 1'b0; upd_a = 1'b0; upd_b = 1'b0;
        tick;
        check("post_rst_busy", {62'd0, busy_a, busy_b}, 64'd0);

        // Fixed single frame
        seg_a = 14'b0110000_1111110; dp_a = 2'b01;
        fc = frame_cnt[0];
        upd_a = 1'b1; tick; upd_a = 1'b0;
        wait_idle(0, 200);
        verify(0, "fixed", model(2, 48'(seg_a), 8'(dp_a)), 16, 66, 2, fc, 1);
        check("fixed_const", last_frame[0], 64'h30FE);

        // Random frames with inputs changed mid-frame
        repeat (4) begin
            seg_a = 14'($urandom); dp_a = 2'($urandom);
            e1 = model(2, 48'(seg_a), 8'(dp_a));
            fc = frame_cnt[0];
            upd_a = 1'b1; tick; upd_a = 1'b0;
            wait_bits_a(5);
            seg_a = 14'($urandom); dp_a = 2'($urandom);
            wait_idle(0, 200);
            verify(0, "midchg", e1, 16, 66, 2, fc, 1);
        end

        // Three coalesced requests produce one follow-on frame with the latest data
        seg_a = 14'($urandom); dp_a = 2'($urandom);
        e1 = model(2, 48'(seg_a), 8'(dp_a));
        fc = frame_cnt[0];
        upd_a = 1'b1; tick; upd_a = 1'b0;
        repeat (10) tick;
        seg_a = 14'($urandom); dp_a = 2'($urandom);
        upd_a = 1'b1; tick; upd_a = 1'b0;
        repeat (20) tick;
        seg_a = 14'($urandom); dp_a = 2'($urandom);
        upd_a = 1'b1; tick; upd_a = 1'b0;
        repeat (15) tick;
        seg_a = 14'($urandom); dp_a = 2'($urandom);
        e2 = model(2, 48'(seg_a), 8'(dp_a));
        upd_a = 1'b1; tick; upd_a = 1'b0;
        wait_idle(0, 400);
        verify(0, "pending", e2, 16, 132, 2, fc, 2);
        check("pending_first", prev_frame[0], e1);

        // Request arriving in the final latch cycle still triggers a follow-on frame
        seg_a = 14'($urandom); dp_a = 2'($urandom);
        e1 = model(2, 48'(seg_a), 8'(dp_a));
        fc = frame_cnt[0];
        upd_a = 1'b1; tick; upd_a = 1'b0;
        begin
            int n = 0;
            while (!lat_a && n < 200) begin
                tick;
                n++;
            end
        end
        check("latch_seen", {63'd0, lat_a}, 64'd1);
        tick;
        seg_a = 14'($urandom); dp_a = 2'($urandom);
        e2 = model(2, 48'(seg_a), 8'(dp_a));
        upd_a = 1'b1; tick; upd_a = 1'b0;
        wait_idle(0, 400);
        verify(0, "lastlat", e2, 16, 132, 2, fc, 2);
        check("lastlat_first", prev_frame[0], e1);

        // Reset mid-frame with a request pending: no latch, no follow-on frame
        seg_a = 14'($urandom); dp_a = 2'($urandom);
        fc = frame_cnt[0];
        upd_a = 1'b1; tick; upd_a = 1'b0;
        wait_bits_a(9);
        upd_a = 1'b1; tick; upd_a = 1'b0;
        rst = 1'b1; tick; rst = 1'b0;
        check("midrst_outs", {60'd0, busy_a, data_a, sclk_a, lat_a}, 64'd0);
        repeat (80) tick;
        check("midrst_no_latch", 64'(frame_cnt[0] - fc), 64'd0);
        check("midrst_idle", {63'd0, busy_a}, 64'd0);
        seg_a = 14'($urandom); dp_a = 2'($urandom);
        fc = frame_cnt[0];
        upd_a = 1'b1; tick; upd_a = 1'b0;
        wait_idle(0, 200);
        verify(0, "afterrst", model(2, 48'(seg_a), 8'(dp_a)), 16, 66, 2, fc, 1);

        // Six digits, divide-by-one
        seg_b = '1; dp_b = '0;
        fc = frame_cnt[1];
        upd_b = 1'b1; tick; upd_b = 1'b0;
        wait_idle(1, 300);
        verify(1, "b_ones", model(6, 48'(seg_b), 8'(dp_b)), 48, 97, 1, fc, 1);
        check("b_ones_const", last_frame[1], 64'h7F7F7F7F7F7F);
        repeat (3) begin
            seg_b = 42'({$urandom, $urandom}); dp_b = 6'($urandom);
            fc = frame_cnt[1];
            upd_b = 1'b1; tick; upd_b = 1'b0;
            wait_idle(1, 300);
            verify(1, "b_rand", model(6, 48'(seg_b), 8'(dp_b)), 48, 97, 1, fc, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_shifter.md
# seven_seg_shifter

Serialises the parallel 7-segment pattern produced by the BCD-to-7-segment stage into a bit stream for an external chain of 8-bit shift registers (74HC595-style: data, shift clock, storage latch). Sits directly downstream of the per-digit segment decoders and is the only path by which segment data leaves the chip, saving pins. One frame carries every digit plus decimal points and ends with a latch pulse, so the display updates atomically.

## Interface

Parameters:
- DIGITS, 6, number of display digits; frame length N = DIGITS*8 bits
- CLK_DIV, 4, system clocks per serial-clock half-period; legal values ≥ 1

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- seven_seg_i  input  DIGITS*7  segment patterns, digit i at [i*7 +: 7], bit 6 = segment a ... bit 0 = segment g
- dp_i  input  DIGITS  decimal point per digit, bit i = digit i
- update_i  input  1  request to send a frame; level-sampled each cycle
- busy_o  output  1  high while a frame is in progress
- ser_data_o  output  1  serial data to shift-register chain
- ser_clk_o  output  1  serial shift clock (external register shifts on its rising edge)
- ser_latch_o  output  1  storage latch strobe

## Operation

- States: IDLE, LOW, HIGH, LATCH. All outputs registered; no combinational path input→output.
- Frame format: digit DIGITS-1 first, digit 0 last; each digit byte = {dp_i[i], seven_seg_i[i*7+6 : i*7]}, MSB first. Bit k of frame sent k-th.
- IDLE: busy_o=0, ser_clk_o=0, ser_latch_o=0, ser_data_o=0. If update_i=1: capture frame into N-bit shift register, bit index ← 0, go LOW.
- LOW: ser_clk_o=0, ser_data_o = current frame bit, held CLK_DIV cycles, then HIGH.
- HIGH: ser_clk_o=1, ser_data_o unchanged, held CLK_DIV cycles. If bit index < N-1: shift, index+1, go LOW; else go LATCH.
- LATCH: ser_clk_o=0, ser_data_o=0, ser_latch_o=1 for CLK_DIV cycles. Then: if pending set, clear pending, recapture inputs (current values at that edge), go LOW directly (busy_o stays 1); else IDLE.
- Pending: update_i=1 in any non-IDLE state sets a one-deep pending flag; multiple requests coalesce. Request in the final LATCH cycle counts.
- Inputs are sampled only at capture; changes mid-frame do not affect the frame in flight.
- Counters: divide counter width max(1,$clog2(CLK_DIV)); bit index width $clog2(N). No wrap beyond N-1.
- Reset (any state, including mid-frame): next edge → IDLE, pending cleared, shift register cleared, all outputs 0. External registers receive no latch for the aborted frame.

## Timing

- Capture edge = cycle 0; busy_o=1 and first bit on ser_data_o from cycle 1.
- Each bit occupies 2*CLK_DIV cycles: data stable CLK_DIV cycles before ser_clk_o rises and throughout high phase.
- ser_latch_o rises 2*N*CLK_DIV cycles after cycle 1, high CLK_DIV cycles.
- busy_o high for exactly 2*N*CLK_DIV + CLK_DIV cycles per frame; falls same cycle state returns to IDLE.
- Back-to-back (pending) frames: no IDLE cycle between latch low and next LOW phase.
- Earliest new capture after returning to IDLE: that same cycle if update_i=1 (busy_o low for one cycle minimum).

## Test plan

- Reset: assert rst_i 2 cycles with update_i=1 → all outputs 0, busy_o=0 during and first cycle after.
- Single frame, DIGITS=2, CLK_DIV=2: seven_seg_i=14'b0110000_1111110 (digit1=0110000, digit0=1111110), dp_i=2'b01, one-cycle update_i → sampled on ser_clk_o rising edges: 0011_0000_1111_1110; one latch pulse 2 cycles wide; busy_o high 66 cycles.
- Mid-frame input change: change seven_seg_i at bit 5 → stream still matches captured value.
- Pending: pulse update_i three times during frame with new data before latch ends → exactly one follow-on frame, starting immediately after latch with data present at recapture; total one extra latch pulse.
- Reset mid-frame at bit 9 → outputs 0 next cycle, no latch pulse, no pending frame afterwards; fresh update_i then produces complete correct frame.
- CLK_DIV=1, DIGITS=6: all-ones segments, dp_i=0 → 48 bits, pattern 0111_1111 repeated 6×, busy_o high 97 cycles.
